serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, giving the operand width in bits; legal values are 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request an addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: operands, captured on start acceptance.
REQ-006 The block SHALL have port cin, input, 1 bit: initial carry, captured on start acceptance.
REQ-007 The block SHALL have ports fa_en, fa_x, fa_y and fa_kin, output, 1 bit each: drive En, X, Y and Kin of the downstream 1-bit full-adder stage.
REQ-008 The block SHALL have ports fa_u and fa_kout, input, 1 bit each: sum and carry returned combinationally by the full-adder stage.
REQ-009 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result register.
REQ-012 The block SHALL have port cout, output, 1 bit: the final carry.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE: IDLE goes to RUN on start=1, RUN goes to DONE after WIDTH RUN cycles, and DONE goes to IDLE unconditionally after one cycle.
REQ-014 On start acceptance, the block SHALL load a and b into right-shift registers, load cin into the carry register, and clear the bit counter.
REQ-015 In RUN, the block SHALL drive fa_en=1, fa_x=a_sh[0], fa_y=b_sh[0] and fa_kin=carry register, which processes the operands LSB first.
REQ-016 At each RUN edge, the block SHALL shift the operand registers right by one, load the carry register from fa_kout, shift fa_u into the MSB of the sum shift register (right shift), and increment the counter.
REQ-017 Outside RUN, the block SHALL drive fa_en=0, fa_x=0, fa_y=0 and fa_kin=0.
REQ-018 On entry to DONE, sum and cout SHALL equal (a+b+cin) mod 2^WIDTH and its carry-out, and both SHALL hold until the next start acceptance.
REQ-019 Timing: start is sampled high at edge N; RUN SHALL occupy the cycles after edges N+1..N+WIDTH; done SHALL be high only in the cycle after edge N+WIDTH+1.
REQ-020 The block SHALL ignore start while busy=1; start held high continuously SHALL begin a new operation on the first edge in IDLE.
REQ-021 Changes to a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-022 The bit counter SHALL be sized to hold WIDTH without overflow, and the RUN exit compare SHALL be exact.
REQ-023 The block SHALL support WIDTH=1 with a single RUN cycle.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force IDLE and clear sum, cout, done, busy, all fa_* outputs, the carry register and the counter, regardless of clk.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done pulse, and a new start after deassertion SHALL behave normally.

Configuration
REQ-026 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output ovf (1 bit) that is valid with sum, equals the carry into the MSB XOR cout, is held like cout, and resets to 0.
REQ-027 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 WIDTH=8, a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, done pulses exactly 9 edges after the accepting edge.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
REQ-030 With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1; a=0x10, b=0x20 -> ovf=0.
REQ-031 Start pulsed again on RUN cycle 3 with different operands -> ignored; the first result is returned and only one done pulse occurs.
REQ-032 rst_n pulsed low on RUN cycle 4 -> all outputs are 0 immediately with no done pulse; the next start with a=0x01, b=0x02 gives sum=0x03.
REQ-033 WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, done 2 edges after acceptance; fa_en is high for exactly one cycle.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial adder controller. It accepts two WIDTH-bit operands and a
// carry-in, then feeds them LSB-first to an external 1-bit full-adder stage,
// one bit per clock. The returned sum bits are collected in a right-shift
// result register.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf.
//
// Ports:
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   start                request an addition (sampled only in IDLE)
//   a, b, cin            operands and carry-in, captured on acceptance
//   fa_en/fa_x/fa_y/fa_kin  drive the full-adder stage (active only in RUN)
//   fa_u, fa_kout        sum and carry returned combinationally by the stage
//   busy                 high in RUN and DONE
//   done                 one-cycle completion pulse (the DONE state)
//   sum, cout            result and final carry, held until the next start
//   ovf                  (SERIAL_ADDER_OVF_EN only) carry-into-MSB ^ cout
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_en,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_kin,
  input  logic             fa_u,
  input  logic             fa_kout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // The counter must reach WIDTH itself, hence WIDTH+1 codes.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic             last_bit;

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    fa_en   = 1'b0;
    fa_x    = 1'b0;
    fa_y    = 1'b0;
    fa_kin  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        fa_en          = 1'b1;
        fa_x           = a_sh_q[0];
        fa_y           = b_sh_q[0];
        fa_kin         = carry_q;
        a_sh_d         = a_sh_q >> 1;
        b_sh_d         = b_sh_q >> 1;
        carry_d        = fa_kout;
        sum_d          = sum_q >> 1;
        sum_d[WIDTH-1] = fa_u;
        cnt_d          = cnt_q + 1'b1;
        if (last_bit) begin
          state_d = DONE;
          cout_d  = fa_kout;
          // On the last bit the carry register holds the carry into the MSB.
          ovf_d   = carry_q ^ fa_kout;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand shifters are pure datapath; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q ^ accept;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 instance ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       en8, x8, y8, kin8, u8, kout8, busy8, done8, cout8;
  logic [7:0] sum8;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8;
`endif

  // Behavioural full-adder stage.
  assign u8    = en8 & (x8 ^ y8 ^ kin8);
  assign kout8 = en8 & ((x8 & y8) | (x8 & kin8) | (y8 & kin8));

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .fa_en(en8), .fa_x(x8), .fa_y(y8), .fa_kin(kin8),
    .fa_u(u8), .fa_kout(kout8), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  // ---------------- WIDTH=1 instance ----------------
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       en1, x1, y1, kin1, u1, kout1, busy1, done1, cout1;
  logic [0:0] sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf1;
`endif

  assign u1    = en1 & (x1 ^ y1 ^ kin1);
  assign kout1 = en1 & ((x1 & y1) | (x1 & kin1) | (y1 & kin1));

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .fa_en(en1), .fa_x(x1), .fa_y(y1), .fa_kin(kin1),
    .fa_u(u1), .fa_kout(kout1), .busy(busy1), .done(done1),
    .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
    exp_t       e;
    logic [8:0] full;
    logic [7:0] low;
    full = {1'b0, a} + {1'b0, b} + {8'd0, c};
    low  = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, c};
    e.s  = full[7:0];
    e.c  = full[8];
    e.v  = low[7] ^ full[8];
    return e;
  endfunction

  // One operation on the WIDTH=8 instance. restart_at / reset_at give the
  // RUN cycle (1..8) at which start is re-pulsed or rst_n is pulsed; 0 = never.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input int restart_at, input int reset_at);
    int   en_cnt, done_cnt, done_at;
    bit   aborted;
    exp_t e, last;
    en_cnt = 0; done_cnt = 0; done_at = 0; aborted = 0;
    last = model(a, b, c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    sb.push_back(last);
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      start8 = 1'b0;
      // Operands wander after acceptance; the result must not follow them.
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (i == restart_at) start8 = 1'b1;
      if (i == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_busy_done", {30'd0, busy8, done8}, 32'd0);
        chk("rst_fa", {28'd0, en8, x8, y8, kin8}, 32'd0);
        aborted = 1;
        void'(sb.pop_front());
      end else begin
        if (en8) en_cnt++;
        if (done8) begin
          done_cnt++;
          done_at = i;
          if (sb.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
          else begin
            e = sb.pop_front();
            chk("sum", 32'(sum8), 32'(e.s));
            chk("cout", 32'(cout8), 32'(e.c));
            chk("busy_in_done", 32'(busy8), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf", 32'(ovf8), 32'(e.v));
`endif
          end
        end
      end
    end
    if (aborted) begin
      chk("abort_no_done", 32'(done_cnt), 32'd0);
    end else begin
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_latency", 32'(done_at), 32'd9);
      chk("fa_en_cycles", 32'(en_cnt), 32'd8);
      chk("sum_held", 32'(sum8), 32'(last.s));
      chk("cout_held", 32'(cout8), 32'(last.c));
      chk("idle_after", 32'(busy8), 32'd0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int en1_cnt;
    #12;
    chk("reset_sum", 32'(sum8), 32'd0);
    chk("reset_ctrl", {29'd0, busy8, done8, en8}, 32'd0);
    chk("reset_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1: 1+1+1 -> sum 1, carry 1, done two edges after acceptance.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    en1_cnt = 0;
    @(negedge clk);
    if (en1) en1_cnt++;
    chk("w1_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    if (en1) en1_cnt++;
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_sum", 32'(sum1), 32'd1);
    chk("w1_cout", 32'(cout1), 32'd1);
    @(negedge clk);
    if (en1) en1_cnt++;
    chk("w1_en_cycles", 32'(en1_cnt), 32'd1);
    chk("w1_idle", 32'(busy1), 32'd0);

    // WIDTH=8 directed cases.
    run_op8(8'h5A, 8'h3C, 1'b0, 0, 0);
    run_op8(8'hFF, 8'h01, 1'b0, 0, 0);
    run_op8(8'h00, 8'h00, 1'b1, 0, 0);
    run_op8(8'h7F, 8'h01, 1'b0, 0, 0);
    run_op8(8'h80, 8'h80, 1'b0, 0, 0);
    run_op8(8'h10, 8'h20, 1'b0, 0, 0);
    run_op8(8'hFF, 8'hFF, 1'b1, 0, 0);
    // Start re-pulsed during RUN must be ignored.
    run_op8(8'h12, 8'h34, 1'b0, 3, 0);
    // Reset mid-run aborts; the following operation must be normal.
    run_op8(8'hC3, 8'h5E, 1'b1, 0, 4);
    run_op8(8'h01, 8'h02, 1'b0, 0, 0);
    // A few random operands.
    for (int k = 0; k < 4; k++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
